mac_output_stage: RTL

- Downstream drain stage for the fixed-point MAC.
- Counts N_TERMS accumulated terms, then captures the 2N-bit Q(2Q) sign-magnitude accumulator.
- Requantizes the capture to N-bit Q(Q) with rounding and saturation, and applies an optional ReLU.
- Presents the result on a valid/ready port and pulses a registered clear that drives the MAC reset for the next dot product.

---
 rtl/mac_output_stage_pkg.sv | 31 +++
 rtl/sm_requant.sv | 47 ++++
 rtl/mac_output_stage.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mac_output_stage_pkg.sv
// Shared types and constants for the MAC drain stage and its requantizer.
// Holds the default operand geometry, the rounding constant, the state
// encoding and the activation select codes.
package mac_output_stage_pkg;

  // Default operand geometry: N-bit Q(Q) operands, 2N-bit Q(2Q) accumulator.
  localparam int unsigned N_DEF   = 8;
  localparam int unsigned Q_DEF   = 5;
  localparam int unsigned ACC_W   = 2 * N_DEF;
  localparam int unsigned ROUND_K = 1 << (Q_DEF - 1);

  // Activation select codes.
  localparam int unsigned ACT_NONE = 0;
  localparam int unsigned ACT_RELU = 1;

  typedef enum logic [0:0] {
    ACCUM   = 1'b0,
    CAPTURE = 1'b1
  } state_e;

  // Half an output LSB expressed in accumulator LSBs (2^(q-1)).
  function automatic int unsigned round_k(input int unsigned q);
    return (q == 0) ? 0 : (1 << (q - 1));
  endfunction

  // Largest sign-magnitude magnitude representable in n bits.
  function automatic int unsigned mag_max(input int unsigned n);
    return (1 << (n - 1)) - 1;
  endfunction

endpackage

// File: rtl/sm_requant.sv
// Combinational requantizer for sign-magnitude values.
// Narrows a 2N-bit Q(2Q) sign-magnitude value to N-bit Q(Q) with
// round-half-away-from-zero, saturation and an optional ReLU.
// Ports:
//   acc        2N-bit sign-magnitude input, MSB is the sign
//   force_sat  force a saturated result (e.g. sticky upstream overflow)
//   data_c     N-bit sign-magnitude result
//   sat_c      result magnitude was clipped
module sm_requant
  import mac_output_stage_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned Q   = Q_DEF,
  parameter int unsigned ACT = ACT_NONE
) (
  input  logic [2*N-1:0] acc,
  input  logic           force_sat,
  output logic [N-1:0]   data_c,
  output logic           sat_c
);

  localparam int unsigned W = 2 * N;
  localparam logic [W-1:0] RND = W'(round_k(Q));
  localparam logic [W-1:0] MAX = W'(mag_max(N));

  logic [W-1:0] rounded;
  logic [W-1:0] shifted;
  logic [N-2:0] mag;
  logic         neg;

  // Adding half an LSB to the magnitude before truncation rounds ties
  // away from zero for both signs. The top bit is cleared so the sum
  // cannot carry out of W bits.
  always_comb begin
    rounded = {1'b0, acc[W-2:0]} + RND;
    shifted = rounded >> Q;
    sat_c   = force_sat | (shifted > MAX);
    mag     = sat_c ? MAX[N-2:0] : shifted[N-2:0];
    // A zero magnitude never carries a sign, so -0 is never produced.
    neg     = acc[W-1] & (mag != '0);
    data_c  = {neg, mag};
    if ((ACT == ACT_RELU) && neg) begin
      data_c = '0;
    end
  end

endmodule

// File: rtl/mac_output_stage.sv
// Drain stage for the fixed-point MAC.
// Counts N_TERMS accepted terms, then captures the MAC accumulator,
// requantizes it and presents it on a valid/ready output register.
// Every capture pulses mac_clear to reset the MAC for the next vector.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   term_valid  upstream presents a product this cycle
//   acc_in      MAC accumulator, 2N-bit sign-magnitude Q(2Q)
//   acc_ovf     MAC adder overflow for the current add
//   out_ready   consumer accepts out_data
//   mac_clear   registered clear to the MAC
//   out_valid   out_data/out_sat hold a result
//   out_data    N-bit sign-magnitude Q(Q) result
//   out_sat     result saturated (range or sticky overflow)
//   busy        waiting to hand a captured result to the output register
module mac_output_stage
  import mac_output_stage_pkg::*;
#(
  parameter int unsigned Q       = Q_DEF,
  parameter int unsigned N       = N_DEF,
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned ACT     = ACT_NONE
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           term_valid,
  input  logic [2*N-1:0] acc_in,
  input  logic           acc_ovf,
  input  logic           out_ready,
  output logic           mac_clear,
  output logic           out_valid,
  output logic [N-1:0]   out_data,
  output logic           out_sat,
  output logic           busy
);

  localparam int unsigned CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, count_inc;
  logic             sticky_q, sticky_d;
  logic             clr_pend_q, clr_pend_d;
  logic             mac_clear_d;
  logic             out_valid_d;
  logic [N-1:0]     out_data_d;
  logic             out_sat_d;
  logic             busy_d;

  logic [N-1:0]     conv_data;
  logic             conv_sat;

  // Requantize whatever the MAC currently holds; only used in CAPTURE,
  // where upstream keeps the accumulator still.
  sm_requant #(
    .N   (N),
    .Q   (Q),
    .ACT (ACT)
  ) u_requant (
    .acc       (acc_in),
    .force_sat (sticky_q),
    .data_c    (conv_data),
    .sat_c     (conv_sat)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sticky_d    = sticky_q;
    clr_pend_d  = 1'b0;
    mac_clear_d = clr_pend_q;
    out_valid_d = out_valid & ~out_ready;
    out_data_d  = out_data;
    out_sat_d   = out_sat;
    count_inc   = count_q + CNT_W'(1);

    case (state_q)
      ACCUM: begin
        // Terms presented while the MAC is being cleared never reach it.
        if (term_valid && !mac_clear) begin
          count_d  = count_inc;
          sticky_d = sticky_q | acc_ovf;
          if (count_inc == LAST) begin
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        // Load when the output register is empty or drains on this edge.
        if (!out_valid || out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = conv_data;
          out_sat_d   = conv_sat;
          mac_clear_d = 1'b1;
          count_d     = '0;
          sticky_d    = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d = ACCUM;
      end
    endcase

    busy_d = (state_d == CAPTURE);
  end

  // State and output registers. Reset raises mac_clear for two cycles via
  // clr_pend so the MAC is cleared even if reset lasts a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ACCUM;
      count_q    <= '0;
      sticky_q   <= 1'b0;
      clr_pend_q <= 1'b1;
      mac_clear  <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      sticky_q   <= sticky_d;
      clr_pend_q <= clr_pend_d;
      mac_clear  <= mac_clear_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_sat    <= out_sat_d;
      busy       <= busy_d;
    end
  end

endmodule
